// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit
//   Decodes the ID-stage MIPS instruction into a control bundle and carries it
//   through the ID/EX, EX/MEM and MEM/WB stage registers. Detects load-use
//   hazards (stall) and branch/jump redirects (flush). Counts undecodable
//   instructions in a saturating counter.
//
// Ports
//   Clk, Reset          clock (rising edge), asynchronous active-high reset
//   opcode, funct       ID instruction [31:26] and [5:0]
//   rs, rt, rd          ID instruction register fields
//   ex_branch_taken     EX-stage branch resolved taken
//   pc_write            PC update enable
//   if_id_write         IF/ID register enable
//   if_id_flush         zero IF/ID on the next edge
//   id_jump, id_jump_reg  j/jal resp. jr in ID (target select)
//   ex_*                ALU op, immediate select, branch, load, destination in EX
//   mem_*               data-memory read/write/size in MEM
//   wb_*                register write, result select, link, write address in WB
//   illegal_count       saturating count of undecodable instructions
module pipelined_control_unit #(
    parameter int ALUOP_W       = 4,
    parameter int REG_W         = 5,
    parameter int CNT_W         = 8,
    parameter bit ENABLE_HAZARD = 1'b1
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic [REG_W-1:0]   rs,
    input  logic [REG_W-1:0]   rt,
    input  logic [REG_W-1:0]   rd,
    input  logic               ex_branch_taken,
    output logic               pc_write,
    output logic               if_id_write,
    output logic               if_id_flush,
    output logic               id_jump,
    output logic               id_jump_reg,
    output logic [ALUOP_W-1:0] ex_ALUOp,
    output logic               ex_ALUSrc,
    output logic               ex_Branch,
    output logic               ex_MemRead,
    output logic [REG_W-1:0]   ex_WriteReg,
    output logic               mem_MemRead,
    output logic               mem_MemWrite,
    output logic [1:0]         mem_MemSize,
    output logic               wb_RegWrite,
    output logic               wb_MemToReg,
    output logic               wb_Link,
    output logic [REG_W-1:0]   wb_WriteReg,
    output logic [CNT_W-1:0]   illegal_count
);

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_SLTI   = 6'b001010;
    localparam logic [5:0] OP_ANDI   = 6'b001100;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_XORI   = 6'b001110;
    localparam logic [5:0] OP_LB     = 6'b100000;
    localparam logic [5:0] OP_LH     = 6'b100001;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SB     = 6'b101000;
    localparam logic [5:0] OP_SH     = 6'b101001;
    localparam logic [5:0] OP_SW     = 6'b101011;

    localparam logic [5:0] F_SLL = 6'b000000;
    localparam logic [5:0] F_SRL = 6'b000010;
    localparam logic [5:0] F_JR  = 6'b001000;
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_XOR = 6'b100110;
    localparam logic [5:0] F_NOR = 6'b100111;
    localparam logic [5:0] F_SLT = 6'b101010;

    typedef struct packed {
        logic             regwrite;
        logic             memtoreg;
        logic             link;
        logic [REG_W-1:0] writereg;
    } wb_t;

    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic [1:0] memsize;
        wb_t        wb;
    } mem_t;

    typedef struct packed {
        logic [ALUOP_W-1:0] aluop;
        logic               alusrc;
        logic               branch;
        mem_t               mem;
    } ex_t;

    function automatic ex_t bubble();
        ex_t b;
        b       = '0;
        b.aluop = '1;
        return b;
    endfunction

    function automatic logic [ALUOP_W-1:0] alu(input logic [3:0] code);
        return ALUOP_W'(code);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    ex_t              dec;
    ex_t              ex_p0;
    mem_t             mem_p1;
    wb_t              wb_p2;
    logic             wr;
    logic [REG_W-1:0] dest;
    logic             illegal;
    logic             uses_rt;
    logic             jump;
    logic             jump_reg;
    logic             load_hit;
    logic             stall;
    logic             hold;
    logic             kill;
    logic             count_en;

    // ---- ID: combinational decode ----
    always_comb begin
        dec      = bubble();
        wr       = 1'b0;
        dest     = '0;
        illegal  = 1'b0;
        uses_rt  = 1'b0;
        jump     = 1'b0;
        jump_reg = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                uses_rt             = 1'b1;
                wr                  = 1'b1;
                dest                = rd;
                dec.mem.wb.memtoreg = 1'b1;
                case (funct)
                    F_ADD:   dec.aluop = alu(4'b0010);
                    F_SUB:   dec.aluop = alu(4'b0011);
                    F_SLT:   dec.aluop = alu(4'b0100);
                    F_AND:   dec.aluop = alu(4'b0000);
                    F_OR:    dec.aluop = alu(4'b0001);
                    F_NOR:   dec.aluop = alu(4'b0101);
                    F_XOR:   dec.aluop = alu(4'b1010);
                    F_SLL:   dec.aluop = alu(4'b1000);
                    F_SRL:   dec.aluop = alu(4'b1001);
                    F_JR: begin
                        // jr writes nothing and travels down as an empty bundle
                        jump_reg            = 1'b1;
                        wr                  = 1'b0;
                        dec.mem.wb.memtoreg = 1'b0;
                    end
                    default: begin
                        illegal = 1'b1;
                        wr      = 1'b0;
                    end
                endcase
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: begin
                wr                  = 1'b1;
                dest                = rt;
                dec.alusrc          = 1'b1;
                dec.mem.wb.memtoreg = 1'b1;
                case (opcode)
                    OP_ADDI: dec.aluop = alu(4'b0010);
                    OP_SLTI: dec.aluop = alu(4'b0100);
                    OP_ANDI: dec.aluop = alu(4'b0000);
                    OP_ORI:  dec.aluop = alu(4'b0001);
                    default: dec.aluop = alu(4'b1010);
                endcase
            end
            OP_LW, OP_LH, OP_LB: begin
                wr              = 1'b1;
                dest            = rt;
                dec.aluop       = alu(4'b0010);
                dec.alusrc      = 1'b1;
                dec.mem.memread = 1'b1;
                dec.mem.memsize = (opcode == OP_LW) ? 2'b00 :
                                  (opcode == OP_LH) ? 2'b01 : 2'b10;
            end
            OP_SW, OP_SH, OP_SB: begin
                uses_rt          = 1'b1;
                dec.aluop        = alu(4'b0010);
                dec.alusrc       = 1'b1;
                dec.mem.memwrite = 1'b1;
                dec.mem.memsize  = (opcode == OP_SW) ? 2'b00 :
                                   (opcode == OP_SH) ? 2'b01 : 2'b10;
            end
            OP_BEQ, OP_BNE: begin
                uses_rt    = 1'b1;
                dec.branch = 1'b1;
                dec.aluop  = alu(4'b0110);
            end
            OP_BGTZ: begin
                dec.branch = 1'b1;
                dec.aluop  = alu(4'b1101);
            end
            OP_BLEZ: begin
                dec.branch = 1'b1;
                dec.aluop  = alu(4'b1110);
            end
            OP_REGIMM: begin
                // bgez/bltz are distinguished by the rt field, not funct
                if (rt == REG_W'(1)) begin
                    dec.branch = 1'b1;
                    dec.aluop  = alu(4'b1100);
                end else if (rt == '0) begin
                    dec.branch = 1'b1;
                    dec.aluop  = alu(4'b1011);
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_J: jump = 1'b1;
            OP_JAL: begin
                jump                = 1'b1;
                wr                  = 1'b1;
                dest                = REG_W'(31);
                dec.mem.wb.link     = 1'b1;
                dec.mem.wb.memtoreg = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        // $0 is hard-wired: a write to it is dropped
        dec.mem.wb.regwrite = wr && (dest != '0);
        dec.mem.wb.writereg = wr ? dest : '0;
    end

    // ---- ID: hazard and redirect control ----
    assign load_hit = ex_p0.mem.memread && (ex_p0.mem.wb.writereg != '0) &&
                      ((ex_p0.mem.wb.writereg == rs) ||
                       (uses_rt && (ex_p0.mem.wb.writereg == rt)));
    assign stall    = ENABLE_HAZARD && load_hit;
    // a taken branch discards the ID instruction, so the stall no longer matters
    assign hold     = stall && !ex_branch_taken;
    assign kill     = ex_branch_taken || stall || illegal;
    assign count_en = illegal && !stall && !ex_branch_taken;

    assign pc_write    = !hold;
    assign if_id_write = !hold;
    assign id_jump     = jump && !stall && !ex_branch_taken;
    assign id_jump_reg = jump_reg && !stall && !ex_branch_taken;
    assign if_id_flush = ex_branch_taken || ((jump || jump_reg) && !stall);

    // ---- ID/EX, EX/MEM, MEM/WB stage registers ----
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ex_p0         <= bubble();
            mem_p1        <= bubble().mem;
            wb_p2         <= bubble().mem.wb;
            illegal_count <= '0;
        end else begin
            ex_p0  <= kill ? bubble() : dec;
            mem_p1 <= ex_p0.mem;
            wb_p2  <= mem_p1.wb;
            if (count_en) begin
                illegal_count <= sat_inc(illegal_count);
            end
        end
    end

    // ---- EX ----
    assign ex_ALUOp    = ex_p0.aluop;
    assign ex_ALUSrc   = ex_p0.alusrc;
    assign ex_Branch   = ex_p0.branch;
    assign ex_MemRead  = ex_p0.mem.memread;
    assign ex_WriteReg = ex_p0.mem.wb.writereg;

    // ---- MEM ----
    assign mem_MemRead  = mem_p1.memread;
    assign mem_MemWrite = mem_p1.memwrite;
    assign mem_MemSize  = mem_p1.memsize;

    // ---- WB ----
    assign wb_RegWrite = wb_p2.regwrite;
    assign wb_MemToReg = wb_p2.memtoreg;
    assign wb_Link     = wb_p2.link;
    assign wb_WriteReg = wb_p2.writereg;

endmodule

// File: tb/tb_pipelined_control_unit.sv
module tb_pipelined_control_unit;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       ex_branch_taken;
    logic       pc_write;
    logic       if_id_write;
    logic       if_id_flush;
    logic       id_jump;
    logic       id_jump_reg;
    logic [3:0] ex_ALUOp;
    logic       ex_ALUSrc;
    logic       ex_Branch;
    logic       ex_MemRead;
    logic [4:0] ex_WriteReg;
    logic       mem_MemRead;
    logic       mem_MemWrite;
    logic [1:0] mem_MemSize;
    logic       wb_RegWrite;
    logic       wb_MemToReg;
    logic       wb_Link;
    logic [4:0] wb_WriteReg;
    logic [7:0] illegal_count;

    pipelined_control_unit dut (
        .Clk(Clk), .Reset(Reset),
        .opcode(opcode), .funct(funct), .rs(rs), .rt(rt), .rd(rd),
        .ex_branch_taken(ex_branch_taken),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_jump(id_jump), .id_jump_reg(id_jump_reg),
        .ex_ALUOp(ex_ALUOp), .ex_ALUSrc(ex_ALUSrc), .ex_Branch(ex_Branch),
        .ex_MemRead(ex_MemRead), .ex_WriteReg(ex_WriteReg),
        .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .mem_MemSize(mem_MemSize),
        .wb_RegWrite(wb_RegWrite), .wb_MemToReg(wb_MemToReg), .wb_Link(wb_Link),
        .wb_WriteReg(wb_WriteReg), .illegal_count(illegal_count)
    );

    always #5 Clk = ~Clk;

    // instruction classes of the reference model
    localparam int K_R = 0, K_JR = 1, K_IALU = 2, K_LD = 3, K_ST = 4, K_BR = 5;
    localparam int K_J = 6, K_JAL = 7, K_ILL = 8;

    // table indices used by the directed sequences
    localparam int I_ADD = 0, I_NOP = 7, I_LW = 15, I_J = 27, I_JAL = 28, I_ILLOP = 29;
    localparam int NINS = 32;

    typedef struct {
        int         kind;
        logic [5:0] op;
        logic [5:0] fn;
        logic [3:0] alu;
        logic [1:0] sz;
        logic       urt;
        logic       fix;
        logic [4:0] rtv;
    } ins_t;

    typedef struct packed {
        logic [3:0] aluop;
        logic       alusrc;
        logic       branch;
        logic       memread;
        logic       memwrite;
        logic [1:0] memsize;
        logic       regwrite;
        logic       memtoreg;
        logic       link;
        logic [4:0] writereg;
    } bnd_t;

    ins_t tbl [NINS];
    bnd_t pipe [3];
    int   mcnt;
    int   total = 0;
    int   bad = 0;
    logic obs_pcw, obs_ifw, obs_fl, obs_j;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic def(input int i, input int kind, input logic [5:0] op, input logic [5:0] fn,
                       input logic [3:0] alu, input logic [1:0] sz, input logic urt,
                       input logic fix, input logic [4:0] rtv);
        tbl[i] = '{kind, op, fn, alu, sz, urt, fix, rtv};
    endtask

    function automatic bnd_t bub();
        bnd_t b;
        b       = '0;
        b.aluop = 4'hF;
        return b;
    endfunction

    function automatic logic [11:0] exv(input bnd_t b);
        return {b.aluop, b.alusrc, b.branch, b.memread, b.writereg};
    endfunction

    function automatic logic [3:0] memv(input bnd_t b);
        return {b.memread, b.memwrite, b.memsize};
    endfunction

    function automatic logic [7:0] wbv(input bnd_t b);
        return {b.regwrite, b.memtoreg, b.link, b.writereg};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) pipe[i] = bub();
        mcnt = 0;
    endtask

    // Present one instruction for one cycle; entered and left just after a rising edge.
    task automatic issue(input int k, input logic [4:0] a_rs, input logic [4:0] a_rt,
                         input logic [4:0] a_rd, input logic tk);
        ins_t       t;
        bnd_t       d;
        bnd_t       nxt;
        logic       ill, urt, jmp, jrg, stl, hold;
        logic [4:0] rtd;
        t   = tbl[k];
        rtd = t.fix ? t.rtv : a_rt;
        opcode          = t.op;
        funct           = (t.op == 6'd0) ? t.fn : 6'($urandom);
        rs              = a_rs;
        rt              = rtd;
        rd              = a_rd;
        ex_branch_taken = tk;

        d   = bub();
        ill = 1'b0;
        jmp = 1'b0;
        jrg = 1'b0;
        urt = (t.op == 6'd0) || t.urt;
        case (t.kind)
            K_R: begin
                d.aluop = t.alu; d.memtoreg = 1'b1;
                d.writereg = a_rd; d.regwrite = (a_rd != 5'd0);
            end
            K_JR: jrg = 1'b1;
            K_IALU: begin
                d.aluop = t.alu; d.alusrc = 1'b1; d.memtoreg = 1'b1;
                d.writereg = rtd; d.regwrite = (rtd != 5'd0);
            end
            K_LD: begin
                d.aluop = 4'b0010; d.alusrc = 1'b1; d.memread = 1'b1; d.memsize = t.sz;
                d.writereg = rtd; d.regwrite = (rtd != 5'd0);
            end
            K_ST: begin
                d.aluop = 4'b0010; d.alusrc = 1'b1; d.memwrite = 1'b1; d.memsize = t.sz;
            end
            K_BR: begin
                d.aluop = t.alu; d.branch = 1'b1;
            end
            K_J: jmp = 1'b1;
            K_JAL: begin
                jmp = 1'b1; d.regwrite = 1'b1; d.link = 1'b1; d.memtoreg = 1'b1;
                d.writereg = 5'd31;
            end
            default: ill = 1'b1;
        endcase

        stl  = pipe[0].memread && (pipe[0].writereg != 5'd0) &&
               ((pipe[0].writereg == a_rs) || (urt && (pipe[0].writereg == rtd)));
        hold = stl && !tk;

        @(negedge Clk);
        obs_pcw = pc_write;
        obs_ifw = if_id_write;
        obs_fl  = if_id_flush;
        obs_j   = id_jump;
        chk("pc_write", 32'(pc_write), 32'(!hold));
        chk("if_id_write", 32'(if_id_write), 32'(!hold));
        chk("if_id_flush", 32'(if_id_flush), 32'(tk || ((jmp || jrg) && !stl)));
        chk("id_jump", 32'(id_jump), 32'(jmp && !stl && !tk));
        chk("id_jump_reg", 32'(id_jump_reg), 32'(jrg && !stl && !tk));
        chk("ex_bundle", 32'({ex_ALUOp, ex_ALUSrc, ex_Branch, ex_MemRead, ex_WriteReg}),
            32'(exv(pipe[0])));
        chk("mem_bundle", 32'({mem_MemRead, mem_MemWrite, mem_MemSize}), 32'(memv(pipe[1])));
        chk("wb_bundle", 32'({wb_RegWrite, wb_MemToReg, wb_Link, wb_WriteReg}),
            32'(wbv(pipe[2])));
        chk("illegal_count", 32'(illegal_count), 32'(mcnt));

        nxt = (tk || stl || ill) ? bub() : d;
        @(posedge Clk);
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = nxt;
        if (ill && !stl && !tk && mcnt < 255) mcnt++;
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        def(0,  K_R,    6'b000000, 6'b100000, 4'b0010, 2'd0, 1'b0, 1'b0, 5'd0);
        def(1,  K_R,    6'b000000, 6'b100010, 4'b0011, 2'd0, 1'b0, 1'b0, 5'd0);
        def(2,  K_R,    6'b000000, 6'b101010, 4'b0100, 2'd0, 1'b0, 1'b0, 5'd0);
        def(3,  K_R,    6'b000000, 6'b100100, 4'b0000, 2'd0, 1'b0, 1'b0, 5'd0);
        def(4,  K_R,    6'b000000, 6'b100101, 4'b0001, 2'd0, 1'b0, 1'b0, 5'd0);
        def(5,  K_R,    6'b000000, 6'b100111, 4'b0101, 2'd0, 1'b0, 1'b0, 5'd0);
        def(6,  K_R,    6'b000000, 6'b100110, 4'b1010, 2'd0, 1'b0, 1'b0, 5'd0);
        def(7,  K_R,    6'b000000, 6'b000000, 4'b1000, 2'd0, 1'b0, 1'b0, 5'd0);
        def(8,  K_R,    6'b000000, 6'b000010, 4'b1001, 2'd0, 1'b0, 1'b0, 5'd0);
        def(9,  K_JR,   6'b000000, 6'b001000, 4'b0000, 2'd0, 1'b0, 1'b0, 5'd0);
        def(10, K_IALU, 6'b001000, 6'b000000, 4'b0010, 2'd0, 1'b0, 1'b0, 5'd0);
        def(11, K_IALU, 6'b001010, 6'b000000, 4'b0100, 2'd0, 1'b0, 1'b0, 5'd0);
        def(12, K_IALU, 6'b001100, 6'b000000, 4'b0000, 2'd0, 1'b0, 1'b0, 5'd0);
        def(13, K_IALU, 6'b001101, 6'b000000, 4'b0001, 2'd0, 1'b0, 1'b0, 5'd0);
        def(14, K_IALU, 6'b001110, 6'b000000, 4'b1010, 2'd0, 1'b0, 1'b0, 5'd0);
        def(15, K_LD,   6'b100011, 6'b000000, 4'b0010, 2'd0, 1'b0, 1'b0, 5'd0);
        def(16, K_LD,   6'b100001, 6'b000000, 4'b0010, 2'd1, 1'b0, 1'b0, 5'd0);
        def(17, K_LD,   6'b100000, 6'b000000, 4'b0010, 2'd2, 1'b0, 1'b0, 5'd0);
        def(18, K_ST,   6'b101011, 6'b000000, 4'b0010, 2'd0, 1'b1, 1'b0, 5'd0);
        def(19, K_ST,   6'b101001, 6'b000000, 4'b0010, 2'd1, 1'b1, 1'b0, 5'd0);
        def(20, K_ST,   6'b101000, 6'b000000, 4'b0010, 2'd2, 1'b1, 1'b0, 5'd0);
        def(21, K_BR,   6'b000100, 6'b000000, 4'b0110, 2'd0, 1'b1, 1'b0, 5'd0);
        def(22, K_BR,   6'b000101, 6'b000000, 4'b0110, 2'd0, 1'b1, 1'b0, 5'd0);
        def(23, K_BR,   6'b000111, 6'b000000, 4'b1101, 2'd0, 1'b0, 1'b0, 5'd0);
        def(24, K_BR,   6'b000110, 6'b000000, 4'b1110, 2'd0, 1'b0, 1'b0, 5'd0);
        def(25, K_BR,   6'b000001, 6'b000000, 4'b1100, 2'd0, 1'b0, 1'b1, 5'd1);
        def(26, K_BR,   6'b000001, 6'b000000, 4'b1011, 2'd0, 1'b0, 1'b1, 5'd0);
        def(27, K_J,    6'b000010, 6'b000000, 4'b0000, 2'd0, 1'b0, 1'b0, 5'd0);
        def(28, K_JAL,  6'b000011, 6'b000000, 4'b0000, 2'd0, 1'b0, 1'b0, 5'd0);
        def(29, K_ILL,  6'b111111, 6'b000000, 4'b0000, 2'd0, 1'b0, 1'b0, 5'd0);
        def(30, K_ILL,  6'b000000, 6'b000001, 4'b0000, 2'd0, 1'b0, 1'b0, 5'd0);
        def(31, K_ILL,  6'b000001, 6'b000000, 4'b0000, 2'd0, 1'b0, 1'b1, 5'd2);

        Reset = 1'b1;
        opcode = '0; funct = '0; rs = '0; rt = '0; rd = '0; ex_branch_taken = 1'b0;
        model_reset();
        @(posedge Clk);
        #1;
        chk("rst_ex_aluop", 32'(ex_ALUOp), 32'hF);
        chk("rst_mem_read", 32'(mem_MemRead), 32'h0);
        chk("rst_wb_regwrite", 32'(wb_RegWrite), 32'h0);
        chk("rst_count", 32'(illegal_count), 32'h0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;

        // add $3,$1,$2
        issue(I_ADD, 5'd1, 5'd2, 5'd3, 1'b0);
        chk("add_ex_aluop", 32'(ex_ALUOp), 32'h2);
        issue(I_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
        issue(I_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("add_wb_regwrite", 32'(wb_RegWrite), 32'h1);
        chk("add_wb_writereg", 32'(wb_WriteReg), 32'd3);
        chk("add_wb_memtoreg", 32'(wb_MemToReg), 32'h1);

        // lw $5,0($1) ; add $6,$5,$2
        issue(I_LW, 5'd1, 5'd5, 5'd0, 1'b0);
        issue(I_ADD, 5'd5, 5'd2, 5'd6, 1'b0);
        chk("lu_pc_write", 32'(obs_pcw), 32'h0);
        chk("lu_if_id_write", 32'(obs_ifw), 32'h0);
        chk("lu_ex_bubble", 32'(ex_ALUOp), 32'hF);
        issue(I_ADD, 5'd5, 5'd2, 5'd6, 1'b0);
        chk("lu_add_late", 32'(ex_ALUOp), 32'h2);
        chk("lu_add_dest", 32'(ex_WriteReg), 32'd6);

        // taken branch while a load-use stall is pending
        issue(I_LW, 5'd1, 5'd4, 5'd0, 1'b0);
        issue(I_ADD, 5'd4, 5'd2, 5'd7, 1'b1);
        chk("br_flush", 32'(obs_fl), 32'h1);
        chk("br_pc_write", 32'(obs_pcw), 32'h1);
        chk("br_ex_bubble", 32'(ex_ALUOp), 32'hF);

        // jump held back by a load-use stall on rs
        issue(I_LW, 5'd0, 5'd3, 5'd0, 1'b0);
        issue(I_J, 5'd3, 5'd0, 5'd0, 1'b0);
        chk("jstall_jump", 32'(obs_j), 32'h0);
        chk("jstall_flush", 32'(obs_fl), 32'h0);

        // jal
        issue(I_JAL, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("jal_jump", 32'(obs_j), 32'h1);
        chk("jal_flush", 32'(obs_fl), 32'h1);
        issue(I_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
        issue(I_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("jal_wb_link", 32'(wb_Link), 32'h1);
        chk("jal_wb_writereg", 32'(wb_WriteReg), 32'd31);
        chk("jal_wb_regwrite", 32'(wb_RegWrite), 32'h1);

        // saturating illegal counter
        for (int i = 0; i < 300; i++) begin
            issue(I_ILLOP, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), 1'b0);
        end
        chk("ill_saturate", 32'(illegal_count), 32'd255);

        // reset mid-stream with a load in MEM
        issue(I_LW, 5'd1, 5'd7, 5'd0, 1'b0);
        issue(I_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("mid_mem_read_before", 32'(mem_MemRead), 32'h1);
        #2;
        Reset = 1'b1;
        #1;
        chk("mid_mem_read", 32'(mem_MemRead), 32'h0);
        chk("mid_count", 32'(illegal_count), 32'h0);
        chk("mid_wb_regwrite", 32'(wb_RegWrite), 32'h0);
        chk("mid_ex_aluop", 32'(ex_ALUOp), 32'hF);
        model_reset();
        @(posedge Clk);
        #1;
        Reset = 1'b0;

        // randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            issue($urandom_range(0, NINS - 1), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 7) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
- Pipelined successor to the single-cycle MIPS control decoder.
- Decodes the ID-stage instruction into a control bundle and carries it through ID/EX, EX/MEM and MEM/WB stage registers.
- Detects load-use hazards (stall) and branch/jump redirects (flush); adds jal/jr support and an illegal-opcode counter.
- Sits between the IF/ID register and the datapath stage registers.

Parameters:
ALUOP_W, 4, ALU operation code width (encodings below occupy the low 4 bits; upper bits zero)
REG_W, 5, register-address width
CNT_W, 8, illegal-opcode counter width
ENABLE_HAZARD, 1, 1 = load-use stall logic active; 0 = stall output tied low

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high reset
opcode  in  6  ID instruction [31:26]
funct  in  6  ID instruction [5:0]
rs  in  REG_W  ID instruction [25:21]
rt  in  REG_W  ID instruction [20:16]
rd  in  REG_W  ID instruction [15:11]
ex_branch_taken  in  1  EX-stage branch resolved taken
pc_write  out  1  PC update enable
if_id_write  out  1  IF/ID register enable
if_id_flush  out  1  zero IF/ID next edge
id_jump  out  1  j/jal in ID (target select)
id_jump_reg  out  1  jr in ID
ex_ALUOp  out  ALUOP_W  ALU operation
ex_ALUSrc  out  1  1 = immediate operand
ex_Branch  out  1  branch instruction in EX
ex_MemRead  out  1  load in EX (hazard/forwarding)
ex_WriteReg  out  REG_W  destination register in EX
mem_MemRead  out  1  data-memory read
mem_MemWrite  out  1  data-memory write
mem_MemSize  out  2  00 word, 01 half, 10 byte
wb_RegWrite  out  1  register-file write
wb_MemToReg  out  1  1 = ALU result, 0 = memory data
wb_Link  out  1  write PC+8 (jal)
wb_WriteReg  out  REG_W  write address
illegal_count  out  CNT_W  saturating count of undecodable opcodes

Behaviour:
- Decode (combinational, ID):
  - R-type funct → ALUOp: add 0010, sub 0011, slt 0100, and 0000, or 0001, nor 0101, xor 1010, sll 1000, srl 1001.
  - jr (funct 001000): id_jump_reg=1, RegWrite=0.
  - Unknown funct: bubble, counts as illegal.
  - I-type ALUOp: addi 0010, slti 0100, andi 0000, ori 0001, xori 1010, lw/sw/lh/sh/lb/sb 0010.
  - Branch ALUOp: beq/bne 0110, bgtz 1101, blez 1110.
  - Opcode 000001 decodes on the rt field: 00001 bgez 1100, 00000 bltz 1011.
  - j/jal: id_jump=1. jal: RegWrite=1, Link=1, WriteReg=31.
  - Destination: rd for R-type, rt for I-type, 31 for jal.
  - Any write to register 0 → RegWrite forced 0.
- Bubble: all write/read/branch/link bits 0, ALUOp all-ones, WriteReg 0.
- Latency: instruction in ID at cycle n appears on ex_* at n+1, mem_* at n+2, wb_* at n+3. EX/MEM and MEM/WB always advance.
- Load-use stall:
  - stall = ENABLE_HAZARD & ex_MemRead & (ex_WriteReg≠0) & (ex_WriteReg==rs | (uses_rt & ex_WriteReg==rt)).
  - uses_rt is true for R-type, stores, beq and bne.
  - On stall: pc_write=0, if_id_write=0, bubble into ID/EX.
- Flush:
  - ex_branch_taken → if_id_flush=1, bubble into ID/EX; ID instruction discarded.
  - ID j/jal/jr (not stalled, no taken branch) → if_id_flush=1; the jump itself proceeds into ID/EX.
- Simultaneous events:
  - ex_branch_taken overrides stall: pc_write=1, if_id_write=1, flush=1.
  - A jump stalled by load-use asserts neither id_jump nor flush until the stall clears.
- Illegal opcode/funct: bubble into ID/EX; illegal_count +1 per cycle presented (not while stalled or flushed); saturates at all-ones.
- Reset (asynchronous): all stage registers to bubble, illegal_count=0. Combinational outputs follow decode of the current inputs. Reset mid-stream discards all in-flight bundles.

Test Plan:
- Reset asserted mid-stream with lw in MEM → mem_MemRead drops to 0 immediately; illegal_count=0; wb_RegWrite=0.
- add $3,$1,$2 (funct 100000, rd=3) → ex_ALUOp=0010 at n+1, wb_RegWrite=1, wb_WriteReg=3, wb_MemToReg=1 at n+3.
- lw $5,0($1) then add $6,$5,$2 → one cycle of pc_write=0, if_id_write=0, bubble in EX; add reaches EX one cycle late.
- beq in EX with ex_branch_taken=1 while a load-use stall is also present → if_id_flush=1, pc_write=1, ex_* bubble next cycle.
- jal → id_jump=1, if_id_flush=1; three cycles later wb_Link=1, wb_WriteReg=31, wb_RegWrite=1.
- 300 consecutive illegal opcodes 111111 with CNT_W=8 → illegal_count saturates at 255; no writes issued.
